mips_stim_sequencer: RTL
========================

// Module: mips_stim_sequencer
// PURPOSE
//  Stimulus/check end of the MIPS core reference-model interface. Accepts symbolic ops (fields, operands, expected
//  value), encodes the 32-bit MIPS word and drives instruction + rs/rt contents to a core or golden model.
//  Captures the returned result, compares it to the expected value and keeps pass/fail/timeout statistics.
//  Sits between the test-vector source and the DUT/golden model in the core verification harness.
// PARAMETERS
//  CNT_W    16  width of each statistics counter (saturating)
//  TIMEOUT  64  max cycles in WAIT for result_valid before the op is declared timed out (>=1)
// PORTS
//  clk           in   1   single clock, rising edge
//  reset         in   1   asynchronous, active-high
//  req_valid     in   1   request offered
//  req_ready     out  1   sequencer can accept a request
//  req_op        in   4   op select: 0 ADD,1 SUB,2 AND,3 OR,4 SLL,5 SRL,6 SRA,7 SLTU,8 ADDI,9 ADDIU,10 ANDI,11 ORI,12 SLTI,13 LUI
//  req_rs/rt/rd  in   5   register fields (rd, shamt ignored for I-type)
//  req_shamt     in   5   shift amount
//  req_imm       in   16  immediate (ignored for R-type)
//  req_rs_data   in   32  rs content to present
//  req_rt_data   in   32  rt content to present
//  req_expected  in   32  expected result
//  issue_valid   out  1   instruction/operands valid toward DUT
//  issue_ready   in   1   DUT accepts issue
//  instr         out  32  encoded instruction word
//  rs_content    out  32  registered rs operand
//  rt_content    out  32  registered rt operand
//  result_valid  in   1   DUT result strobe
//  result        in   32  DUT result
//  pass_cnt, fail_cnt, timeout_cnt, illegal_cnt  out  CNT_W  statistics
//  err_sticky    out  1   set on any fail/timeout/illegal/protocol error; cleared only by reset
//  last_err_instr out 32  instr word of most recent failing or timed-out op
// BEHAVIOUR
//  Reset: state IDLE; issue_valid=0; req_ready=1 (after reset); instr/rs_content/rt_content=0; all counters 0;
//   err_sticky=0; last_err_instr=0. Reset mid-operation abandons the op with no counter update.
//  FSM IDLE -> ISSUE -> WAIT -> CHECK -> IDLE. req_ready = (state==IDLE).
//  IDLE: on req_valid&req_ready latch all fields; req_op>13 -> illegal_cnt++, err_sticky=1, stay IDLE (no issue).
//   Otherwise load instr/rs_content/rt_content and go ISSUE (issue_valid=1 the cycle after acceptance).
//  ISSUE: issue_valid=1; instr/operands held stable until issue_ready; on issue_valid&issue_ready -> WAIT, clear timer.
//  WAIT: result_valid -> capture result, go CHECK. Else timer++; timer==TIMEOUT-1 with no result -> timeout_cnt++,
//   err_sticky=1, last_err_instr=instr, go IDLE. result_valid on the same cycle as expiry: result wins.
//  CHECK (1 cycle): result==expected -> pass_cnt++; else fail_cnt++, err_sticky=1, last_err_instr=instr. -> IDLE.
//  result_valid asserted in IDLE or ISSUE is a protocol error: err_sticky=1, value ignored, no counter change.
//  Min throughput: accept(N), issue(N+1), result(N+2 earliest), check(N+3), next accept N+4.
//  Counters saturate at all-ones; no wrap.
//  Encoding: R-type {6'd0,rs,rt,rd,shamt,funct}; funct ADD 32,SUB 34,AND 36,OR 37,SLL 0,SRL 2,SRA 3,SLTU 43.
//   I-type {opcode,rs,rt,imm}; opcode ADDI 8,ADDIU 9,ANDI 12,ORI 13,SLTI 10,LUI 15. For SLL/SRL/SRA rs field forced 0.
// STRUCTURE
//  Shared package mips_tb_pkg: op enum (OP_ADD..OP_LUI), OPC_* and FUNCT_* constants, state encoding.
//  One sub-module: mips_instr_encode (combinational: op+fields -> 32-bit word + legal flag), also reused by benches.
// TESTING
//  ADD rs=1 rt=2 rd=3, rs_data=5 rt_data=7 exp=12, DUT returns 12 -> instr 0x00221820, pass_cnt=1.
//  ADDI rs=4 rt=5 imm=0xFFFF -> instr 0x2085FFFF; SLL rt=2 rd=3 shamt=4 -> 0x00021900; LUI rt=1 imm=0x1234 -> 0x3C011234.
//  issue_ready held low 5 cycles -> issue_valid and instr stable all 5 cycles, single issue on handshake.
//  No result_valid for TIMEOUT cycles -> timeout_cnt=1, err_sticky=1, last_err_instr=issued word, req_ready returns.
//  SUB exp=0xFFFFFFFE, DUT returns 0 -> fail_cnt=1, err_sticky=1; then req_op=14 -> illegal_cnt=1, issue_valid stays 0.
//  Assert reset during WAIT -> next cycle state IDLE, all counters 0, issue_valid=0, req_ready=1 after release.

Source files
------------

// File: rtl/mips_tb_pkg.sv
// Shared definitions for the MIPS stimulus sequencer: op selects, opcode/funct
// constants and the sequencer state encoding.
package mips_tb_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_SLL   = 4'd4,
        OP_SRL   = 4'd5,
        OP_SRA   = 4'd6,
        OP_SLTU  = 4'd7,
        OP_ADDI  = 4'd8,
        OP_ADDIU = 4'd9,
        OP_ANDI  = 4'd10,
        OP_ORI   = 4'd11,
        OP_SLTI  = 4'd12,
        OP_LUI   = 4'd13
    } op_e;

    localparam logic [5:0] OPC_RTYPE  = 6'd0;
    localparam logic [5:0] OPC_ADDI   = 6'd8;
    localparam logic [5:0] OPC_ADDIU  = 6'd9;
    localparam logic [5:0] OPC_SLTI   = 6'd10;
    localparam logic [5:0] OPC_ANDI   = 6'd12;
    localparam logic [5:0] OPC_ORI    = 6'd13;
    localparam logic [5:0] OPC_LUI    = 6'd15;

    localparam logic [5:0] FUNCT_SLL  = 6'd0;
    localparam logic [5:0] FUNCT_SRL  = 6'd2;
    localparam logic [5:0] FUNCT_SRA  = 6'd3;
    localparam logic [5:0] FUNCT_ADD  = 6'd32;
    localparam logic [5:0] FUNCT_SUB  = 6'd34;
    localparam logic [5:0] FUNCT_AND  = 6'd36;
    localparam logic [5:0] FUNCT_OR   = 6'd37;
    localparam logic [5:0] FUNCT_SLTU = 6'd43;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_CHECK = 2'd3;

endpackage

// File: rtl/mips_stim_sequencer_if.sv
// Request, issue, result and statistics signals of the stimulus sequencer.
// master = sequencer side, slave = vector source / core / harness side.
interface mips_stim_sequencer_if #(parameter int CNT_W = 16);

    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [4:0]       req_rs;
    logic [4:0]       req_rt;
    logic [4:0]       req_rd;
    logic [4:0]       req_shamt;
    logic [15:0]      req_imm;
    logic [31:0]      req_rs_data;
    logic [31:0]      req_rt_data;
    logic [31:0]      req_expected;

    logic             issue_valid;
    logic             issue_ready;
    logic [31:0]      instr;
    logic [31:0]      rs_content;
    logic [31:0]      rt_content;

    logic             result_valid;
    logic [31:0]      result;

    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [CNT_W-1:0] timeout_cnt;
    logic [CNT_W-1:0] illegal_cnt;
    logic             err_sticky;
    logic [31:0]      last_err_instr;

    modport master (
        input  req_valid, req_op, req_rs, req_rt, req_rd, req_shamt, req_imm,
               req_rs_data, req_rt_data, req_expected, issue_ready, result_valid, result,
        output req_ready, issue_valid, instr, rs_content, rt_content,
               pass_cnt, fail_cnt, timeout_cnt, illegal_cnt, err_sticky, last_err_instr
    );

    modport slave (
        output req_valid, req_op, req_rs, req_rt, req_rd, req_shamt, req_imm,
               req_rs_data, req_rt_data, req_expected, issue_ready, result_valid, result,
        input  req_ready, issue_valid, instr, rs_content, rt_content,
               pass_cnt, fail_cnt, timeout_cnt, illegal_cnt, err_sticky, last_err_instr
    );

endinterface

// File: rtl/mips_instr_encode.sv
// Combinational encoder: symbolic op + register/immediate fields -> 32-bit MIPS word.
// o_legal is low for op selects outside the supported set.
module mips_instr_encode
    import mips_tb_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_shamt,
    input  logic [15:0] i_imm,
    output logic [31:0] o_instr,
    output logic        o_legal
);

    always_comb begin
        o_instr = '0;
        o_legal = 1'b1;
        case (i_op)
            OP_ADD:   o_instr = {OPC_RTYPE, i_rs, i_rt, i_rd, i_shamt, FUNCT_ADD};
            OP_SUB:   o_instr = {OPC_RTYPE, i_rs, i_rt, i_rd, i_shamt, FUNCT_SUB};
            OP_AND:   o_instr = {OPC_RTYPE, i_rs, i_rt, i_rd, i_shamt, FUNCT_AND};
            OP_OR:    o_instr = {OPC_RTYPE, i_rs, i_rt, i_rd, i_shamt, FUNCT_OR};
            OP_SLTU:  o_instr = {OPC_RTYPE, i_rs, i_rt, i_rd, i_shamt, FUNCT_SLTU};
            // Shifts take their source from rt; the rs field must encode as zero.
            OP_SLL:   o_instr = {OPC_RTYPE, 5'd0, i_rt, i_rd, i_shamt, FUNCT_SLL};
            OP_SRL:   o_instr = {OPC_RTYPE, 5'd0, i_rt, i_rd, i_shamt, FUNCT_SRL};
            OP_SRA:   o_instr = {OPC_RTYPE, 5'd0, i_rt, i_rd, i_shamt, FUNCT_SRA};
            OP_ADDI:  o_instr = {OPC_ADDI,  i_rs, i_rt, i_imm};
            OP_ADDIU: o_instr = {OPC_ADDIU, i_rs, i_rt, i_imm};
            OP_ANDI:  o_instr = {OPC_ANDI,  i_rs, i_rt, i_imm};
            OP_ORI:   o_instr = {OPC_ORI,   i_rs, i_rt, i_imm};
            OP_SLTI:  o_instr = {OPC_SLTI,  i_rs, i_rt, i_imm};
            OP_LUI:   o_instr = {OPC_LUI,   i_rs, i_rt, i_imm};
            default:  o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_stim_sequencer.sv
// Drives encoded MIPS ops and operands to a core/golden model, checks the returned
// result against the expected value and keeps saturating pass/fail/timeout/illegal statistics.
module mips_stim_sequencer
    import mips_tb_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
)
(
    input  logic                  clk,
    input  logic                  reset,
    mips_stim_sequencer_if.master bus
);

    localparam int              TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [TMR_W-1:0] r_timer;
    logic [31:0]      r_instr;
    logic [31:0]      r_rs_content;
    logic [31:0]      r_rt_content;
    logic [31:0]      r_expected;
    logic [31:0]      r_result;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic [CNT_W-1:0] r_timeout_cnt;
    logic [CNT_W-1:0] r_illegal_cnt;
    logic             r_err_sticky;
    logic [31:0]      r_last_err_instr;
    logic [31:0]      w_instr;
    logic             w_legal;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    mips_instr_encode u_encode (
        .i_op    (bus.req_op),
        .i_rs    (bus.req_rs),
        .i_rt    (bus.req_rt),
        .i_rd    (bus.req_rd),
        .i_shamt (bus.req_shamt),
        .i_imm   (bus.req_imm),
        .o_instr (w_instr),
        .o_legal (w_legal)
    );

    // Expected/result are pure datapath and need no reset.
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && bus.req_valid && w_legal)
            r_expected <= bus.req_expected;
        if (r_state == ST_WAIT && bus.result_valid)
            r_result <= bus.result;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_timer          <= '0;
            r_instr          <= '0;
            r_rs_content     <= '0;
            r_rt_content     <= '0;
            r_pass_cnt       <= '0;
            r_fail_cnt       <= '0;
            r_timeout_cnt    <= '0;
            r_illegal_cnt    <= '0;
            r_err_sticky     <= 1'b0;
            r_last_err_instr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        if (!w_legal) begin
                            r_illegal_cnt <= sat_inc(r_illegal_cnt);
                            r_err_sticky  <= 1'b1;
                        end else begin
                            r_instr      <= w_instr;
                            r_rs_content <= bus.req_rs_data;
                            r_rt_content <= bus.req_rt_data;
                            r_state      <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.issue_ready) begin
                        r_timer <= '0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A result arriving on the expiry cycle still counts as a result.
                    if (bus.result_valid) begin
                        r_state <= ST_CHECK;
                    end else if (r_timer == TMR_LAST) begin
                        r_timeout_cnt    <= sat_inc(r_timeout_cnt);
                        r_err_sticky     <= 1'b1;
                        r_last_err_instr <= r_instr;
                        r_state          <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (r_result == r_expected) begin
                        r_pass_cnt <= sat_inc(r_pass_cnt);
                    end else begin
                        r_fail_cnt       <= sat_inc(r_fail_cnt);
                        r_err_sticky     <= 1'b1;
                        r_last_err_instr <= r_instr;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
            if (bus.result_valid && (r_state == ST_IDLE || r_state == ST_ISSUE))
                r_err_sticky <= 1'b1;
        end
    end

    assign bus.req_ready      = (r_state == ST_IDLE);
    assign bus.issue_valid    = (r_state == ST_ISSUE);
    assign bus.instr          = r_instr;
    assign bus.rs_content     = r_rs_content;
    assign bus.rt_content     = r_rt_content;
    assign bus.pass_cnt       = r_pass_cnt;
    assign bus.fail_cnt       = r_fail_cnt;
    assign bus.timeout_cnt    = r_timeout_cnt;
    assign bus.illegal_cnt    = r_illegal_cnt;
    assign bus.err_sticky     = r_err_sticky;
    assign bus.last_err_instr = r_last_err_instr;

endmodule
